// File: rtl/periph_req_agent_pkg.sv
// Shared types and constants for the DMA peripheral request agent.
// The peripheral slot range is 31:1. Bit 0 does not exist.
package periph_pkg;

    typedef enum logic [1:0] {
        P_IDLE,
        P_REQ,
        P_HOLD
    } preq_state_t;

    localparam int PERIPH_LSB = 1;
    localparam int PERIPH_MSB = 31;

endpackage

// File: rtl/periph_req_agent_if.sv
// Handshake bundle between the peripheral side and the DMA controller.
// The master modport is the environment: it drives the peripheral levels
// and the DMA clears. The slave modport is the request agent.
interface periph_req_agent_if;
    import periph_pkg::*;

    logic [PERIPH_MSB:PERIPH_LSB] tx_ready;
    logic [PERIPH_MSB:PERIPH_LSB] rx_ready;
    logic [PERIPH_MSB:PERIPH_LSB] tx_en;
    logic [PERIPH_MSB:PERIPH_LSB] rx_en;
    logic [PERIPH_MSB:PERIPH_LSB] periph_tx_clr;
    logic [PERIPH_MSB:PERIPH_LSB] periph_rx_clr;
    logic                         err_clr;
    logic [PERIPH_MSB:PERIPH_LSB] periph_tx_req;
    logic [PERIPH_MSB:PERIPH_LSB] periph_rx_req;
    logic [PERIPH_MSB:PERIPH_LSB] tx_err;
    logic [PERIPH_MSB:PERIPH_LSB] rx_err;

    modport master (
        output tx_ready, rx_ready, tx_en, rx_en,
        output periph_tx_clr, periph_rx_clr, err_clr,
        input  periph_tx_req, periph_rx_req, tx_err, rx_err
    );

    modport slave (
        input  tx_ready, rx_ready, tx_en, rx_en,
        input  periph_tx_clr, periph_rx_clr, err_clr,
        output periph_tx_req, periph_rx_req, tx_err, rx_err
    );

endinterface

// File: rtl/periph_req_agent_chan.sv
// One request engine for a single peripheral slot and direction.
// IDLE -> REQ when enabled and ready. REQ is held until the DMA clear arrives.
// The engine then waits out the hold-off before it can re-arm.
// A clear seen outside REQ latches a sticky error flag.
module periph_req_chan
    import periph_pkg::*;
#(
    parameter int HOLDOFF = 2,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic ready,
    input  logic clr,
    input  logic err_clr,
    output logic req,
    output logic err
);

    // Value loaded into the counter on entry to HOLD. It is unused when HOLDOFF is 0.
    localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : {CW{1'b0}};
    localparam bit            NO_HOLD   = (HOLDOFF == 0);

    preq_state_t   state_r;
    logic [CW-1:0] cnt_r;
    logic          req_r;
    logic          err_r;
    logic          spur_s;

    // A clear only makes sense while a request is outstanding.
    assign spur_s = clr && (state_r != P_REQ);

    // Request engine: state, hold-off counter and registered request output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= P_IDLE;
            cnt_r   <= {CW{1'b0}};
            req_r   <= 1'b0;
        end else begin
            case (state_r)
                P_IDLE: begin
                    if (en && ready) begin
                        state_r <= P_REQ;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= P_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                P_REQ: begin
                    // en/ready are ignored here: a request is never withdrawn.
                    if (clr) begin
                        req_r   <= 1'b0;
                        cnt_r   <= HOLD_LOAD;
                        state_r <= NO_HOLD ? P_IDLE : P_HOLD;
                    end else begin
                        req_r   <= 1'b1;
                        state_r <= P_REQ;
                    end
                end
                P_HOLD: begin
                    req_r <= 1'b0;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= P_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                        state_r <= P_HOLD;
                    end
                end
                default: begin
                    state_r <= P_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky spurious-clear flag. A new error wins over a simultaneous err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (spur_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign req = req_r;
    assign err = err_r;

endmodule

// File: rtl/periph_req_agent.sv
// Peripheral-side end of the DMA peripheral handshake. There are 31 TX engines
// and 31 RX engines, one per slot 31:1. The engines are fully independent.
module periph_req_agent
    import periph_pkg::*;
#(
    parameter int HOLDOFF = 2,
    parameter int CW      = 4
) (
    input logic               clk,
    input logic               reset,
    periph_req_agent_if.slave bus
);

    wire [PERIPH_MSB:PERIPH_LSB] tx_req_s;
    wire [PERIPH_MSB:PERIPH_LSB] rx_req_s;
    wire [PERIPH_MSB:PERIPH_LSB] tx_err_s;
    wire [PERIPH_MSB:PERIPH_LSB] rx_err_s;

    for (genvar i = PERIPH_LSB; i <= PERIPH_MSB; i++) begin : g_tx
        periph_req_chan #(
            .HOLDOFF (HOLDOFF),
            .CW      (CW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.tx_en[i]),
            .ready   (bus.tx_ready[i]),
            .clr     (bus.periph_tx_clr[i]),
            .err_clr (bus.err_clr),
            .req     (tx_req_s[i]),
            .err     (tx_err_s[i])
        );
    end

    for (genvar i = PERIPH_LSB; i <= PERIPH_MSB; i++) begin : g_rx
        periph_req_chan #(
            .HOLDOFF (HOLDOFF),
            .CW      (CW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (bus.rx_en[i]),
            .ready   (bus.rx_ready[i]),
            .clr     (bus.periph_rx_clr[i]),
            .err_clr (bus.err_clr),
            .req     (rx_req_s[i]),
            .err     (rx_err_s[i])
        );
    end

    assign bus.periph_tx_req = tx_req_s;
    assign bus.periph_rx_req = rx_req_s;
    assign bus.tx_err        = tx_err_s;
    assign bus.rx_err        = rx_err_s;

endmodule

// File: tb/tb_periph_req_agent.sv
// Directed scoreboard bench for periph_req_agent.
// dut_a uses HOLDOFF=2 and dut_b uses HOLDOFF=0. The stimulus pushes
// cycle-stamped expectations into a queue. The monitor checks them on the
// falling edge of the cycle they name.
module tb_periph_req_agent;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    periph_req_agent_if bus_a ();
    periph_req_agent_if bus_b ();

    periph_req_agent #(.HOLDOFF(2), .CW(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    periph_req_agent #(.HOLDOFF(0), .CW(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        int           cyc;
        int           sel;
        logic [31:1]  exp;
        string        name;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:1] one_hot(int n);
        logic [31:1] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:1] observe(int sel);
        case (sel)
            0: return bus_a.periph_tx_req;
            1: return bus_a.periph_rx_req;
            2: return bus_a.tx_err;
            3: return bus_a.rx_err;
            4: return bus_b.periph_tx_req;
            5: return bus_b.periph_rx_req;
            6: return bus_b.tx_err;
            default: return bus_b.rx_err;
        endcase
    endfunction

    task automatic expect_at(int c, int sel, logic [31:1] v, string nm);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation due this cycle and flags any that were missed.
    always @(negedge clk) begin
        int i;
        logic [31:1] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                act   = observe(q[i].sel);
                total = total + 1;
                if (act !== q[i].exp) begin
                    bad = bad + 1;
                    $display("FAIL %s cyc=%0d sel=%0d got=%h want=%h",
                             q[i].name, cyc, q[i].sel, act, q[i].exp);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL %s stale cyc=%0d want=%h", q[i].name, q[i].cyc, q[i].exp);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        logic [31:1] all_m;
        logic [31:1] odd_m;
        logic [31:1] even_m;
        int c;
        int w;

        all_m = '1;
        odd_m = '0;
        for (int k = 1; k <= 31; k += 2) odd_m[k] = 1'b1;
        even_m = ~odd_m;

        reset = 1'b1;
        bus_a.tx_ready = '0; bus_a.rx_ready = '0; bus_a.tx_en = '0; bus_a.rx_en = '0;
        bus_a.periph_tx_clr = '0; bus_a.periph_rx_clr = '0; bus_a.err_clr = 1'b0;
        bus_b.tx_ready = '0; bus_b.rx_ready = '0; bus_b.tx_en = '0; bus_b.rx_en = '0;
        bus_b.periph_tx_clr = '0; bus_b.periph_rx_clr = '0; bus_b.err_clr = 1'b0;

        // Reset state.
        tick(2);
        c = cyc;
        for (int s = 0; s < 8; s++) expect_at(c, s, '0, "reset_state");
        reset = 1'b0;
        tick(1);

        // Basic TX handshake on slot 5.
        c = cyc;
        bus_a.tx_en = one_hot(5);
        bus_a.tx_ready = one_hot(5);
        expect_at(c, 0, '0, "tx5_before");
        for (int k = 1; k <= 4; k++) expect_at(c + k, 0, one_hot(5), "tx5_req");
        for (int k = 5; k <= 7; k++) expect_at(c + k, 0, '0, "tx5_holdoff");
        expect_at(c + 8, 0, one_hot(5), "tx5_rearm");
        tick(4);
        bus_a.periph_tx_clr = one_hot(5);
        tick(1);
        bus_a.periph_tx_clr = '0;
        tick(3);
        bus_a.periph_tx_clr = one_hot(5);
        bus_a.tx_en = '0;
        bus_a.tx_ready = '0;
        expect_at(c + 9, 0, '0, "tx5_clr2");
        expect_at(c + 12, 0, '0, "tx5_quiet");
        expect_at(c + 12, 2, '0, "tx5_noerr");
        tick(1);
        bus_a.periph_tx_clr = '0;
        tick(3);

        // No withdrawal on RX slot 31.
        c = cyc;
        bus_a.rx_en = one_hot(31);
        bus_a.rx_ready = one_hot(31);
        expect_at(c, 1, '0, "rx31_before");
        for (int k = 1; k <= 11; k++) expect_at(c + k, 1, one_hot(31), "rx31_held");
        for (int k = 12; k <= 16; k++) expect_at(c + k, 1, '0, "rx31_cleared");
        expect_at(c + 16, 3, '0, "rx31_noerr");
        tick(1);
        bus_a.rx_en = '0;
        bus_a.rx_ready = '0;
        tick(10);
        bus_a.periph_rx_clr = one_hot(31);
        tick(1);
        bus_a.periph_rx_clr = '0;
        tick(4);

        // Spurious clear on idle TX slot 1, err_clr with and without a new error.
        c = cyc;
        bus_a.periph_tx_clr = one_hot(1);
        for (int k = 1; k <= 3; k++) begin
            expect_at(c + k, 2, one_hot(1), "tx1_err_sticky");
            expect_at(c + k, 0, '0, "tx1_no_req");
        end
        expect_at(c + 4, 2, one_hot(1), "tx1_set_wins");
        expect_at(c + 5, 2, '0, "tx1_err_cleared");
        tick(1);
        bus_a.periph_tx_clr = '0;
        tick(2);
        bus_a.err_clr = 1'b1;
        bus_a.periph_tx_clr = one_hot(1);
        tick(1);
        bus_a.periph_tx_clr = '0;
        tick(1);
        bus_a.err_clr = 1'b0;
        tick(1);

        // All-channel concurrency, then an asynchronous reset mid-operation.
        c = cyc;
        bus_a.tx_en = all_m; bus_a.tx_ready = all_m;
        bus_a.rx_en = all_m; bus_a.rx_ready = all_m;
        for (int k = 1; k <= 2; k++) begin
            expect_at(c + k, 0, all_m, "all_tx_req");
            expect_at(c + k, 1, all_m, "all_rx_req");
        end
        for (int k = 3; k <= 5; k++) begin
            expect_at(c + k, 0, even_m, "odd_tx_gap");
            expect_at(c + k, 1, even_m, "odd_rx_gap");
        end
        expect_at(c + 6, 0, all_m, "all_tx_rearm");
        expect_at(c + 6, 1, all_m, "all_rx_rearm");
        expect_at(c + 3, 2, '0, "all_tx_noerr");
        for (int k = 4; k <= 6; k++) expect_at(c + k, 2, odd_m, "odd_tx_spur_err");
        expect_at(c + 6, 3, '0, "all_rx_noerr");
        for (int k = 7; k <= 9; k++)
            for (int s = 0; s < 4; s++) expect_at(c + k, s, '0, "async_reset");
        expect_at(c + 10, 0, all_m, "post_reset_tx");
        expect_at(c + 10, 1, all_m, "post_reset_rx");
        expect_at(c + 10, 2, '0, "post_reset_txerr");
        expect_at(c + 10, 3, '0, "post_reset_rxerr");
        expect_at(c + 11, 0, '0, "final_tx_clr");
        expect_at(c + 11, 1, '0, "final_rx_clr");
        tick(2);
        bus_a.periph_tx_clr = odd_m;
        bus_a.periph_rx_clr = odd_m;
        tick(1);
        bus_a.periph_tx_clr = odd_m;
        bus_a.periph_rx_clr = '0;
        tick(1);
        bus_a.periph_tx_clr = '0;
        tick(2);
        bus_a.periph_tx_clr = even_m;
        bus_a.periph_rx_clr = even_m;
        tick(1);
        bus_a.periph_tx_clr = '0;
        bus_a.periph_rx_clr = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        bus_a.periph_tx_clr = all_m;
        bus_a.periph_rx_clr = all_m;
        bus_a.tx_en = '0; bus_a.tx_ready = '0;
        bus_a.rx_en = '0; bus_a.rx_ready = '0;
        tick(1);
        bus_a.periph_tx_clr = '0;
        bus_a.periph_rx_clr = '0;
        tick(4);

        // HOLDOFF=0: back-to-back clears every other cycle on TX slot 7.
        c = cyc;
        bus_b.tx_en = one_hot(7);
        bus_b.tx_ready = one_hot(7);
        expect_at(c, 4, '0, "h0_before");
        for (int k = 1; k <= 9; k++)
            expect_at(c + k, 4, (k % 2 == 1) ? one_hot(7) : '0, "h0_toggle");
        expect_at(c + 9, 6, '0, "h0_noerr");
        tick(1);
        for (int k = 0; k < 4; k++) begin
            bus_b.periph_tx_clr = one_hot(7);
            tick(1);
            bus_b.periph_tx_clr = '0;
            tick(1);
        end

        tick(2);
        w = 0;
        while (q.size() > 0 && w < 50) begin
            tick(1);
            w++;
        end
        while (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s never_checked cyc=%0d want=%h", q[0].name, q[0].cyc, q[0].exp);
            void'(q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_req_agent.md
# periph_req_agent

Peripheral-side end of the DMA peripheral handshake. For each of the 31 peripheral slots (bit indices 31:1; bit 0 does not exist), it raises a TX request when the peripheral can accept data and an RX request when the peripheral holds data. Each request is held until the DMA controller returns a one-cycle clear. After a programmable hold-off, the request re-arms. The block sits between the peripheral models/buffers and the DMA controller's `periph_tx_req`/`periph_rx_req` inputs.

## Interface
Parameters:
- `HOLDOFF`, default 2: cycles a channel stays quiet after a clear before it may re-request; legal range 0..15.
- `CW`, default 4: hold-off counter width; must satisfy 2^CW > HOLDOFF.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_ready`  in  [31:1]  peripheral n has room for a TX burst (level).
- `rx_ready`  in  [31:1]  peripheral n has an RX burst available (level).
- `tx_en`, `rx_en`  in  [31:1]  per-channel enable masks.
- `periph_tx_clr`  in  [31:1]  DMA acknowledge for TX; one-cycle pulse.
- `periph_rx_clr`  in  [31:1]  DMA acknowledge for RX; one-cycle pulse.
- `err_clr`  in  1  synchronous clear of all error bits.
- `periph_tx_req`  out  [31:1]  TX request to the DMA controller.
- `periph_rx_req`  out  [31:1]  RX request to the DMA controller.
- `tx_err`, `rx_err`  out  [31:1]  sticky spurious-clear flags.

## Operation
- There are 62 independent channel engines, one per bit per direction. TX and RX are identical.
- Each engine has three states:
  - IDLE (`req`=0): if `en & ready`, go to REQ; otherwise stay.
  - REQ (`req`=1): if `clr`, go to HOLD, or straight to IDLE when `HOLDOFF`=0; otherwise stay. A request is never withdrawn. Deasserting `en` or `ready` while in REQ has no effect until `clr` arrives.
  - HOLD (`req`=0): the counter loads `HOLDOFF-1` on entry. If the counter is 0, go to IDLE; otherwise decrement. `ready` and `en` are ignored in HOLD.
- `req` is decoded from the registered state (`state==REQ`); there is no combinational path from inputs to `req`.
- Spurious clear: `clr` sampled while in IDLE or HOLD sets the sticky `err` bit. The state is unaffected.
- `err_clr` clears every `err` bit on the next edge.
- If `err_clr` and a spurious `clr` occur in the same cycle, the error is set (set wins).
- Reset: all engines go to IDLE, counters to 0, and all `req` and `err` outputs to 0, immediately and asynchronously. A request outstanding at reset is dropped, and the DMA side must tolerate this.

## Timing
- Request latency: `en & ready` true before edge t gives `req`=1 after edge t (1 cycle).
- Clear latency: `clr`=1 sampled at edge t gives `req`=0 after edge t.
- Re-request gap with `ready` held high: `req` drops after edge t and rises again after edge t+HOLDOFF+1. With `HOLDOFF`=2, the low gap is 3 cycles; with `HOLDOFF`=0, it is 1 cycle.
- A `clr` coinciding with the cycle `req` first rises is accepted: REQ is already the state at that edge, so it is not flagged as spurious.
- A second `clr` in the cycle after an accepted clear lands in HOLD or IDLE and is flagged as an error.
- Channels never interact. Simultaneous events on any subset of the 62 engines are processed independently in the same cycle.

## Structure
- Shared package `periph_pkg` holds:
  - `typedef enum logic [1:0] {P_IDLE, P_REQ, P_HOLD} preq_state_t`;
  - `localparam PERIPH_LSB = 1` and `PERIPH_MSB = 31`.
- Sub-module `periph_req_chan` implements one engine: ports `clk`, `reset`, `en`, `ready`, `clr`, `err_clr`, `req`, `err`, with parameters `HOLDOFF` and `CW`.
- The top level instantiates it via two generate loops over indices 1..31, one for TX and one for RX.

## Test plan
- Basic TX handshake:
  - Stimulus: reset, then `tx_en[5]`=1, `tx_ready[5]`=1; pulse `periph_tx_clr[5]` 4 cycles after `req` rises.
  - Required response: `periph_tx_req[5]` high 1 cycle after `ready`, low right after `clr`, high again 3 cycles later (`HOLDOFF`=2).
- No withdrawal:
  - Stimulus: `rx_req[31]` asserted, then `rx_ready[31]` and `rx_en[31]` dropped for 10 cycles.
  - Required response: `req` stays 1 until `periph_rx_clr[31]`, then 0 and stays 0.
- Spurious clear:
  - Stimulus: pulse `periph_tx_clr[1]` while idle.
  - Required response: `tx_err[1]`=1, sticky; no `req`.
  - Stimulus: `err_clr` together with another spurious `clr`.
  - Required response: `tx_err[1]` remains 1.
  - Stimulus: `err_clr` alone.
  - Required response: `tx_err[1]` returns to 0.
- All-channel concurrency:
  - Stimulus: all 62 channels enabled and ready; clear odd-index channels only.
  - Required response: odd channels follow the hold-off gap; even channels stay high; no errors.
- Mid-operation reset:
  - Stimulus: assert `reset` asynchronously (between edges) with channels in REQ and HOLD.
  - Required response: all `req`/`err` outputs go to 0 without waiting for an edge; after release, requests reappear 1 cycle after the first edge.
- Parameter corner:
  - Stimulus: `HOLDOFF`=0 with continuous `ready` and back-to-back `clr` every other cycle.
  - Required response: `req` toggles 1/0 with zero errors.
